// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for the RV32I multicycle datapath.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes and bad branch funct3.
module multicycle_ctrl #(
    parameter logic [2:0] I = 3'd0,
    parameter logic [2:0] S = 3'd1,
    parameter logic [2:0] B = 3'd2,
    parameter logic [2:0] U = 3'd3,
    parameter logic [2:0] J = 3'd4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [2:0] o_im_type,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_result_src,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JALR   = 4'd10,
        JLINK  = 4'd11,
        LUI    = 4'd12,
        TRAP   = 4'd15
    } state_t;

    state_t state, next_state;

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic unused_funct3;
    assign unused_funct3 = ^i_funct3[2:1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FETCH;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = FETCH;
        o_im_type    = 3'd0;
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        o_adr_src    = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 2'd0;
        o_alu_src_b  = 2'd0;
        o_alu_op     = 2'd0;
        o_result_src = 2'd0;
        o_illegal    = 1'b0;
        o_state      = state;

        if (state != FETCH) begin
            case (i_opcode)
                OP_LW, OP_IALU, OP_JALR: o_im_type = I;
                OP_SW:                   o_im_type = S;
                OP_BRANCH:               o_im_type = B;
                OP_LUI, OP_AUIPC:        o_im_type = U;
                OP_JAL:                  o_im_type = J;
                default:                 o_im_type = 3'd0;
            endcase
        end

        case (state)
            FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'd2;
                o_result_src = 2'd2;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
                next_state   = i_mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                o_alu_src_a = 2'd1;
                o_alu_src_b = 2'd1;
                case (i_opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_IALU:      next_state = EXECI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    OP_BRANCH:    next_state = (i_funct3[2:1] == 2'b00) ? BRANCH : TRAP;
`else
                    OP_BRANCH:    next_state = BRANCH;
`endif
                    OP_JAL:       next_state = JLINK;
                    OP_JALR:      next_state = JALR;
                    OP_LUI:       next_state = LUI;
                    OP_AUIPC:     next_state = ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      next_state = TRAP;
`else
                    default:      next_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                o_alu_src_a = 2'd2;
                o_alu_src_b = 2'd1;
                next_state  = (i_opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                o_adr_src  = 1'b1;
                o_mem_req  = 1'b1;
                next_state = i_mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                o_result_src = 2'd1;
                o_reg_write  = 1'b1;
            end
            MEMWR: begin
                o_adr_src   = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_write = 1'b1;
                next_state  = i_mem_ready ? FETCH : MEMWR;
            end
            EXECR: begin
                o_alu_src_a = 2'd2;
                o_alu_op    = 2'd2;
                next_state  = ALUWB;
            end
            EXECI: begin
                o_alu_src_a = 2'd2;
                o_alu_src_b = 2'd1;
                o_alu_op    = 2'd2;
                next_state  = ALUWB;
            end
            ALUWB: begin
                o_reg_write = 1'b1;
            end
            BRANCH: begin
                // bit 0 of funct3 inverts the sense, so beq and bne share one rule
                o_alu_src_a = 2'd2;
                o_alu_op    = 2'd1;
                o_pc_write  = i_funct3[0] ^ i_zero;
            end
            JALR: begin
                o_alu_src_a = 2'd2;
                o_alu_src_b = 2'd1;
                next_state  = JLINK;
            end
            JLINK: begin
                o_alu_src_a = 2'd1;
                o_alu_src_b = 2'd2;
                o_pc_write  = 1'b1;
                next_state  = ALUWB;
            end
            LUI: begin
                o_alu_src_a = 2'd3;
                o_alu_src_b = 2'd1;
                next_state  = ALUWB;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                o_illegal  = 1'b1;
                next_state = TRAP;
            end
`endif
            default: next_state = FETCH;
        endcase

        // Reset kills everything immediately, including an in-flight memory request
        if (!i_rst_n) begin
            o_im_type    = 3'd0;
            o_pc_write   = 1'b0;
            o_ir_write   = 1'b0;
            o_adr_src    = 1'b0;
            o_mem_req    = 1'b0;
            o_mem_write  = 1'b0;
            o_reg_write  = 1'b0;
            o_alu_src_a  = 2'd0;
            o_alu_src_b  = 2'd0;
            o_alu_op     = 2'd0;
            o_result_src = 2'd0;
            o_illegal    = 1'b0;
            o_state      = 4'd0;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM controller for the RV32I multicycle uprocesador datapath.
- Sequences fetch, decode, execute, memory and writeback, with a req/ready handshake to unified memory.
- Drives the immediate-format select of the sign extender, plus the ALU, register-file, PC and IR enables.
- Sits between the instruction register/ALU flags and the datapath muxes.

Parameters:
- I, 3'd0, im_type code for I-format
- S, 3'd1, im_type code for S-format
- B, 3'd2, im_type code for B-format
- U, 3'd3, im_type code for U-format
- J, 3'd4, im_type code for J-format

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_opcode  in  7  IR[6:0]
- i_funct3  in  3  IR[14:12]
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes the current request this cycle
- o_im_type  out  3  immediate format select for the sign extender
- o_pc_write  out  1  PC load
- o_ir_write  out  1  IR and oldPC load
- o_adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- o_mem_req  out  1  memory request
- o_mem_write  out  1  request is a write
- o_reg_write  out  1  register-file write
- o_alu_src_a  out  2  ALU A select: 0=PC, 1=oldPC, 2=rs1, 3=zero
- o_alu_src_b  out  2  ALU B select: 0=rs2, 1=imm, 2=const 4
- o_alu_op  out  2  ALU operation: 0=add, 1=sub, 2=funct decode
- o_result_src  out  2  result select: 0=ALUOut, 1=data reg, 2=ALU result
- o_state  out  4  current state, for debug
- o_illegal  out  1  trap flag

Behaviour:
- State register: 4 bits, asynchronous clear to FETCH (0).
- All outputs are decoded from state (Moore), except the ready-qualified writes noted below.
- While i_rst_n=0, every output is forced to 0 combinationally. o_mem_req drops immediately if reset arrives mid-request; the in-flight transaction is abandoned.
- Unlisted outputs are 0 in each state.
- o_im_type is combinational from i_opcode in every state except FETCH (0 in FETCH):
  - lw, I-alu, jalr -> I
  - sw -> S
  - branch -> B
  - lui, auipc -> U
  - jal -> J
  - anything else -> 0
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-alu 0010011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
- Memory handshake: in a memory state, o_mem_req is held high until a rising edge samples i_mem_ready=1. Ready-qualified outputs (o_ir_write, o_pc_write in FETCH) assert only in the cycle where i_mem_ready=1. i_mem_ready while o_mem_req=0 is ignored.
- States (encoding / outputs / next):
  - FETCH 0: adr_src=0, mem_req=1, src_a=0, src_b=2, alu_op=0, result_src=2. On ready: ir_write=1, pc_write=1 -> DECODE; else stay.
  - DECODE 1: src_a=1, src_b=1, alu_op=0 (ALUOut<=oldPC+imm).
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-alu -> EXECI
    - branch -> BRANCH
    - jal -> JLINK
    - jalr -> JALR
    - lui -> LUI
    - auipc -> ALUWB
    - other -> see optional feature
  - MEMADR 2: src_a=2, src_b=1, alu_op=0 -> MEMRD if lw, MEMWR if sw.
  - MEMRD 3: adr_src=1, mem_req=1; ready -> MEMWB.
  - MEMWB 4: result_src=1, reg_write=1 -> FETCH.
  - MEMWR 5: adr_src=1, mem_req=1, mem_write=1; ready -> FETCH.
  - EXECR 6: src_a=2, src_b=0, alu_op=2 -> ALUWB.
  - EXECI 7: src_a=2, src_b=1, alu_op=2 -> ALUWB.
  - ALUWB 8: result_src=0, reg_write=1 -> FETCH.
  - BRANCH 9: src_a=2, src_b=0, alu_op=1, result_src=0, pc_write=(funct3[0] ^ i_zero) -> FETCH. funct3 000 = beq, 001 = bne.
  - JALR 10: src_a=2, src_b=1, alu_op=0 -> JLINK.
  - JLINK 11: src_a=1, src_b=2, alu_op=0, result_src=0, pc_write=1 -> ALUWB (rd<=oldPC+4).
  - LUI 12: src_a=3, src_b=1, alu_op=0 -> ALUWB.
  - TRAP 15: illegal=1; holds until reset.
- Cycles per instruction, zero-wait memory: lw 5; sw 4; R/I 4; branch 3; jal 4; jalr 5; lui 4; auipc 3. Each wait cycle adds 1.
- Unused encodings 13, 14 -> FETCH next cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
- Defined: in DECODE, an unknown opcode, or a branch with funct3 not in {000,001}, goes to TRAP; o_illegal=1 and no further memory requests are issued until reset.
- Undefined: unknown opcode -> FETCH (executes as NOP, 2 cycles); all branch funct3 use the funct3[0] rule; TRAP is unreachable and o_illegal is tied to 0.

Test Plan:
- Reset low mid-FETCH with o_mem_req=1 -> o_mem_req=0 immediately and o_state=0; after release, FETCH req reasserts on the first cycle.
- lw (opcode 0000011), ready=1 always -> o_state 0,1,2,3,4,0; reg_write only in state 4 with result_src=1; o_im_type=0 from DECODE onward.
- sw with ready delayed 3 cycles in MEMWR -> o_mem_req=o_mem_write=1 held for 4 cycles, o_im_type=1, then FETCH.
- beq with i_zero=1 -> pc_write=1 in BRANCH; bne with i_zero=1 -> pc_write=0; o_im_type=2.
- jalr -> states 1,10,11,8; pc_write in JLINK; o_im_type=0. jal skips 10; o_im_type=4.
- Opcode 1111111: with the macro, o_state=15 and o_illegal=1 persist 20 cycles; without, o_state returns to 0 after DECODE.
